v_data_mem: RTL and testbench
=============================

// Module: v_data_mem
// PURPOSE
// Four-bank, word-interleaved data memory shared by the scalar core and the vector coprocessor.
// Ports 0-3 each own one bank (bank i) for byte-masked writes and synchronous reads, so a vector unit can move 4 words/cycle.
// A fifth read-only port (con_*) reads any word of the unified space for the console/debug interface.
// PARAMETERS
// ADDR_BITS   14   word-address width (`DATAMEM_BITS); bank = addr[1:0], row = addr[ADDR_BITS-1:2]
// DATA_WIDTH  32   word width (`DATAMEM_WIDTH); 4 byte lanes
// BANK_DEPTH  2**(ADDR_BITS-2)   words per bank; 4 banks fixed
// PORTS
// core_clk    in   1           single clock; all ports sample on rising edge
// nrst        in   1           asynchronous active-low reset
// dm_write_i  in   4           (i=0..3) byte-write enables for bank i; bit k writes byte k [8k+7:8k]
// data_addr   in   ADDR_BITS   port-0 word address (bank 0)
// data_addr1..data_addr3  in  ADDR_BITS  port-1..3 word addresses (banks 1..3)
// data_in_i   in   DATA_WIDTH  (i=0..3) write data for bank i
// con_addr    in   ADDR_BITS   console read word address (any bank)
// data_out_i  out  DATA_WIDTH  (i=0..3) registered read data of bank i
// con_out     out  DATA_WIDTH  registered console read data
// BEHAVIOUR
// - Port i always targets bank i at row addr_i[ADDR_BITS-1:2]; addr_i[1:0] ignored (caller keeps it == i).
// - Write: at posedge, for each k with dm_write_i[k]=1, bank_i[row][8k+7:8k] <= data_in_i[8k+7:8k];
//   dm_write_i=0 -> no write even if address/data toggle. Partial masks leave other bytes unchanged.
// - All four ports write independently in the same cycle (distinct banks, no conflicts).
// - Read port i: data_out_i <= bank_i[row_i] every posedge; 1-cycle latency, read-first
//   (same-cycle write to same row returns OLD word; new word visible next cycle).
// - Console: con_out <= bank[con_addr[1:0]][con_addr[ADDR_BITS-1:2]] each posedge; 1-cycle latency,
//   read-first vs any concurrent port write to the same word.
// - con_addr X/undriven: con_out undefined until a valid address is applied; no side effects.
// - Reset (nrst=0, async): data_out_0..3 and con_out cleared to 0 immediately and held while low.
//   Memory contents NOT cleared (block RAM); writes suppressed while nrst=0.
// - Address wrap: row uses only addr[ADDR_BITS-1:2]; max address (all ones) is bank 3 last row.
// - Uninitialised words read as X in simulation; optional $readmemh init is not required.
// - Must infer 4 independent byte-enabled BRAMs (one per bank) plus output muxing for con_out.
// TESTING
// 1. Bank-0 write: dm_write_0=F, others 0, addr 0 data F0F0F0F0, then addr 4 A0A0A0A0 ->
//    later con_addr=0 gives F0F0F0F0, con_addr=4 gives A0A0A0A0; banks 1-3 row 0 untouched.
// 2. Per-bank writes: bank1 addr1=F0F0F0F0, addr5=A0A0A0A0; bank2 addr2=B0B0B0B0, addr6=CCCCCCCC;
//    bank3 addr3=DDDDDDDD, addr7=EEEEEEEE -> con_addr 1,5,2,6,3,7 return those words 1 cycle later.
// 3. Parallel vector write: all dm_write=F, addrs 8,9,10,11 data 11111111..44444444, next cycle
//    12..15 data 55555555..88888888 -> con_addr 8..15 return 11111111..88888888 in order.
// 4. Byte mask: word 0=F0F0F0F0, write dm_write_0=4'b0101 data 12345678 -> read F034F078.
// 5. Read-during-write: write 0xAAAAAAAA to addr 4 via port 0 with data_addr=4 -> data_out_0 shows
//    old A0A0A0A0 on that edge, AAAAAAAA on the following edge.
// 6. Reset: assert nrst mid-read -> data_out_* and con_out go 0 asynchronously; after release,
//    con_addr=9 returns 22222222 (contents preserved).

Source files
------------

// File: rtl/v_data_mem_if.sv
// rtl/v_data_mem_if.sv - port bundle for the four-bank data memory
interface v_data_mem_if #(
  parameter int ADDR_BITS  = 14,
  parameter int DATA_WIDTH = 32
);

  // Per-bank byte-write enables
  logic [3:0]            dm_write_0;
  logic [3:0]            dm_write_1;
  logic [3:0]            dm_write_2;
  logic [3:0]            dm_write_3;

  // Per-bank word addresses (port i always lands in bank i)
  logic [ADDR_BITS-1:0]  data_addr;
  logic [ADDR_BITS-1:0]  data_addr1;
  logic [ADDR_BITS-1:0]  data_addr2;
  logic [ADDR_BITS-1:0]  data_addr3;

  // Per-bank write data
  logic [DATA_WIDTH-1:0] data_in_0;
  logic [DATA_WIDTH-1:0] data_in_1;
  logic [DATA_WIDTH-1:0] data_in_2;
  logic [DATA_WIDTH-1:0] data_in_3;

  // Console read address into the unified word space
  logic [ADDR_BITS-1:0]  con_addr;

  // Registered read data
  logic [DATA_WIDTH-1:0] data_out_0;
  logic [DATA_WIDTH-1:0] data_out_1;
  logic [DATA_WIDTH-1:0] data_out_2;
  logic [DATA_WIDTH-1:0] data_out_3;
  logic [DATA_WIDTH-1:0] con_out;

  modport master (
    output dm_write_0, dm_write_1, dm_write_2, dm_write_3,
    output data_addr, data_addr1, data_addr2, data_addr3,
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output con_addr,
    input  data_out_0, data_out_1, data_out_2, data_out_3,
    input  con_out
  );

  modport slave (
    input  dm_write_0, dm_write_1, dm_write_2, dm_write_3,
    input  data_addr, data_addr1, data_addr2, data_addr3,
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  con_addr,
    output data_out_0, data_out_1, data_out_2, data_out_3,
    output con_out
  );

endinterface

// File: rtl/v_data_mem.sv
// rtl/v_data_mem.sv - four-bank word-interleaved data memory with console read port
module v_data_mem #(
  parameter int ADDR_BITS  = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic         core_clk,
  input  logic         nrst,
  v_data_mem_if.slave  bus
);

  localparam int ROW_BITS   = ADDR_BITS - 2;
  localparam int BANK_DEPTH = 1 << ROW_BITS;
  localparam int NUM_BANKS  = 4;
  localparam int LANES      = DATA_WIDTH / 8;

  // Gathered per-bank views of the individually named port signals
  logic [NUM_BANKS-1:0][LANES-1:0]      bank_we;
  logic [NUM_BANKS-1:0][ROW_BITS-1:0]   bank_row;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_din;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] port_rd;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] con_rd;

  logic [ROW_BITS-1:0]   con_row;
  logic [1:0]            con_bank_d;
  logic [1:0]            con_bank_q;
  logic [DATA_WIDTH-1:0] con_out_d;

  // Port addresses carry their bank number in the low bits; the bank is
  // fixed by which port is used, so those bits are deliberately dropped.
  logic unused_port_bank_bits;

  assign bank_we  = {bus.dm_write_3, bus.dm_write_2, bus.dm_write_1, bus.dm_write_0};
  assign bank_din = {bus.data_in_3, bus.data_in_2, bus.data_in_1, bus.data_in_0};
  assign bank_row = {bus.data_addr3[ADDR_BITS-1:2], bus.data_addr2[ADDR_BITS-1:2],
                     bus.data_addr1[ADDR_BITS-1:2], bus.data_addr[ADDR_BITS-1:2]};

  assign unused_port_bank_bits = ^{bus.data_addr[1:0], bus.data_addr1[1:0],
                                   bus.data_addr2[1:0], bus.data_addr3[1:0]};

  assign con_row    = bus.con_addr[ADDR_BITS-1:2];
  assign con_bank_d = bus.con_addr[1:0];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : bank_g
    // Storage has no reset so it maps onto block RAM; contents survive nrst
    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] con_rd_q;

    // Byte-lane writes from the owning port, held off while reset is asserted
    always_ff @(posedge core_clk) begin
      for (int k = 0; k < LANES; k++) begin
        if (nrst && bank_we[b][k]) begin
          mem[bank_row[b]][8*k +: 8] <= bank_din[b][8*k +: 8];
        end
      end
    end

    // Owning-port read; non-blocking sample gives the pre-write (old) word
    always_ff @(posedge core_clk or negedge nrst) begin
      if (!nrst) begin
        rd_q <= '0;
      end else begin
        rd_q <= mem[bank_row[b]];
      end
    end

    // Console-side read of this bank at the console row, also read-first
    always_ff @(posedge core_clk or negedge nrst) begin
      if (!nrst) begin
        con_rd_q <= '0;
      end else begin
        con_rd_q <= mem[con_row];
      end
    end

    assign port_rd[b] = rd_q;
    assign con_rd[b]  = con_rd_q;
  end

  // Remember which bank the console asked for so the matching read can be picked
  always_ff @(posedge core_clk or negedge nrst) begin
    if (!nrst) begin
      con_bank_q <= 2'd0;
    end else begin
      con_bank_q <= con_bank_d;
    end
  end

  // Select the console word from the four registered bank reads
  always_comb begin
    con_out_d = con_rd[0];
    case (con_bank_q)
      2'd0:    con_out_d = con_rd[0];
      2'd1:    con_out_d = con_rd[1];
      2'd2:    con_out_d = con_rd[2];
      default: con_out_d = con_rd[3];
    endcase
  end

  assign bus.data_out_0 = port_rd[0];
  assign bus.data_out_1 = port_rd[1];
  assign bus.data_out_2 = port_rd[2];
  assign bus.data_out_3 = port_rd[3];
  assign bus.con_out    = con_out_d;

endmodule

// File: tb/tb_v_data_mem.sv
// tb/tb_v_data_mem.sv - self-checking bench for the four-bank data memory
module tb_v_data_mem;

  localparam int AB = 14;
  localparam int DW = 32;

  logic core_clk = 1'b0;
  logic nrst;

  always #5 core_clk = ~core_clk;

  v_data_mem_if #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) bus ();

  v_data_mem #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) dut (
    .core_clk (core_clk),
    .nrst     (nrst),
    .bus      (bus)
  );

  typedef struct {
    logic [3:0][3:0]    we;
    logic [3:0][AB-1:0] addr;
    logic [3:0][DW-1:0] din;
    logic [AB-1:0]      con_addr;
    bit                 chk;
    logic [DW-1:0]      con_exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Reference: one flat word-addressed space with per-byte written flags
  logic [DW-1:0] model_mem [0:(1<<AB)-1];
  logic [3:0]    model_vld [0:(1<<AB)-1];

  vec_t vecs [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic model_write(input int addr, input logic [3:0] m, input logic [DW-1:0] d);
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        model_mem[addr][8*k +: 8] = d[8*k +: 8];
        model_vld[addr][k] = 1'b1;
      end
    end
  endtask

  // Port p writes the word whose unified address is its row with bank number p
  task automatic model_ports(input logic [3:0][3:0] we, input logic [3:0][AB-1:0] a,
                             input logic [3:0][DW-1:0] d);
    for (int p = 0; p < 4; p++) begin
      model_write((int'(a[p][AB-1:2]) * 4) + p, we[p], d[p]);
    end
  endtask

  task automatic set_bus(input logic [3:0][3:0] we, input logic [3:0][AB-1:0] a,
                         input logic [3:0][DW-1:0] d, input logic [AB-1:0] ca);
    bus.dm_write_0 = we[0];
    bus.dm_write_1 = we[1];
    bus.dm_write_2 = we[2];
    bus.dm_write_3 = we[3];
    bus.data_addr  = a[0];
    bus.data_addr1 = a[1];
    bus.data_addr2 = a[2];
    bus.data_addr3 = a[3];
    bus.data_in_0  = d[0];
    bus.data_in_1  = d[1];
    bus.data_in_2  = d[2];
    bus.data_in_3  = d[3];
    bus.con_addr   = ca;
  endtask

  function automatic logic [DW-1:0] dout(input int p);
    case (p)
      0:       return bus.data_out_0;
      1:       return bus.data_out_1;
      2:       return bus.data_out_2;
      default: return bus.data_out_3;
    endcase
  endfunction

  function automatic vec_t v_wr4(input logic [3:0][3:0] we, input logic [3:0][AB-1:0] a,
                                 input logic [3:0][DW-1:0] d);
    vec_t v;
    v.we = we; v.addr = a; v.din = d;
    v.con_addr = '0; v.chk = 1'b0; v.con_exp = '0;
    return v;
  endfunction

  function automatic vec_t v_wr1(input int p, input logic [3:0] m, input logic [AB-1:0] a,
                                 input logic [DW-1:0] d);
    vec_t v;
    v = v_wr4('0, '0, '0);
    v.we[p] = m; v.addr[p] = a; v.din[p] = d;
    return v;
  endfunction

  function automatic vec_t v_rd(input logic [AB-1:0] ca, input logic [DW-1:0] exp);
    vec_t v;
    v = v_wr4('0, '0, '0);
    v.con_addr = ca; v.chk = 1'b1; v.con_exp = exp;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < (1<<AB); i++) begin
      model_vld[i] = 4'h0;
      model_mem[i] = '0;
    end
    set_bus('0, '0, '0, '0);
    nrst = 1'b1;
    #1 nrst = 1'b0;
    #1;
    check("reset_dout0", bus.data_out_0, 32'h0);
    check("reset_dout1", bus.data_out_1, 32'h0);
    check("reset_dout2", bus.data_out_2, 32'h0);
    check("reset_dout3", bus.data_out_3, 32'h0);
    check("reset_con",   bus.con_out,    32'h0);
    step();
    step();
    nrst = 1'b1;

    // Directed vectors: single-bank, per-bank, parallel, readback, mask, idle, wrap
    vecs.push_back(v_wr1(0, 4'hF, 14'd0, 32'hF0F0F0F0));
    vecs.push_back(v_wr1(0, 4'hF, 14'd4, 32'hA0A0A0A0));
    vecs.push_back(v_wr4({4'hF, 4'hF, 4'hF, 4'h0}, {14'd3, 14'd2, 14'd1, 14'd0},
                         {32'hDDDDDDDD, 32'hB0B0B0B0, 32'hF0F0F0F0, 32'h0}));
    vecs.push_back(v_wr4({4'hF, 4'hF, 4'hF, 4'h0}, {14'd7, 14'd6, 14'd5, 14'd0},
                         {32'hEEEEEEEE, 32'hCCCCCCCC, 32'hA0A0A0A0, 32'h0}));
    vecs.push_back(v_wr4({4'hF, 4'hF, 4'hF, 4'hF}, {14'd11, 14'd10, 14'd9, 14'd8},
                         {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}));
    vecs.push_back(v_wr4({4'hF, 4'hF, 4'hF, 4'hF}, {14'd15, 14'd14, 14'd13, 14'd12},
                         {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555}));
    vecs.push_back(v_rd(14'd0, 32'hF0F0F0F0));
    vecs.push_back(v_rd(14'd4, 32'hA0A0A0A0));
    vecs.push_back(v_rd(14'd1, 32'hF0F0F0F0));
    vecs.push_back(v_rd(14'd5, 32'hA0A0A0A0));
    vecs.push_back(v_rd(14'd2, 32'hB0B0B0B0));
    vecs.push_back(v_rd(14'd6, 32'hCCCCCCCC));
    vecs.push_back(v_rd(14'd3, 32'hDDDDDDDD));
    vecs.push_back(v_rd(14'd7, 32'hEEEEEEEE));
    vecs.push_back(v_rd(14'd8,  32'h11111111));
    vecs.push_back(v_rd(14'd9,  32'h22222222));
    vecs.push_back(v_rd(14'd10, 32'h33333333));
    vecs.push_back(v_rd(14'd11, 32'h44444444));
    vecs.push_back(v_rd(14'd12, 32'h55555555));
    vecs.push_back(v_rd(14'd13, 32'h66666666));
    vecs.push_back(v_rd(14'd14, 32'h77777777));
    vecs.push_back(v_rd(14'd15, 32'h88888888));
    vecs.push_back(v_wr1(0, 4'b0101, 14'd0, 32'h12345678));
    vecs.push_back(v_rd(14'd0, 32'hF034F078));
    vecs.push_back(v_wr4('0, {14'd7, 14'd6, 14'd5, 14'd4},
                         {32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404}));
    vecs.push_back(v_rd(14'd4, 32'hA0A0A0A0));
    vecs.push_back(v_rd(14'd5, 32'hA0A0A0A0));
    vecs.push_back(v_wr1(3, 4'hF, 14'h3FFF, 32'hCAFEF00D));
    vecs.push_back(v_rd(14'h3FFF, 32'hCAFEF00D));
    vecs.push_back(v_rd(14'd3, 32'hDDDDDDDD));

    foreach (vecs[i]) begin
      set_bus(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].con_addr);
      step();
      model_ports(vecs[i].we, vecs[i].addr, vecs[i].din);
      if (vecs[i].chk) check($sformatf("vec%0d_con", i), bus.con_out, vecs[i].con_exp);
    end

    // Read-during-write on port 0 and on the console: old word first, new word next
    set_bus({4'h0, 4'h0, 4'h0, 4'hF}, {14'd0, 14'd0, 14'd0, 14'd4},
            {32'h0, 32'h0, 32'h0, 32'hAAAAAAAA}, 14'd4);
    step();
    model_write(4, 4'hF, 32'hAAAAAAAA);
    check("rdw_dout0_old", bus.data_out_0, 32'hA0A0A0A0);
    check("rdw_con_old",   bus.con_out,    32'hA0A0A0A0);
    bus.dm_write_0 = 4'h0;
    step();
    check("rdw_dout0_new", bus.data_out_0, 32'hAAAAAAAA);
    check("rdw_con_new",   bus.con_out,    32'hAAAAAAAA);

    // Asynchronous reset mid-cycle, blocked write during reset, contents kept
    set_bus('0, {14'd11, 14'd10, 14'd9, 14'd8}, '0, 14'd9);
    step();
    check("pre_rst_dout0", bus.data_out_0, 32'h11111111);
    check("pre_rst_dout3", bus.data_out_3, 32'h44444444);
    #3 nrst = 1'b0;
    #1;
    check("rst_dout0", bus.data_out_0, 32'h0);
    check("rst_dout1", bus.data_out_1, 32'h0);
    check("rst_dout2", bus.data_out_2, 32'h0);
    check("rst_dout3", bus.data_out_3, 32'h0);
    check("rst_con",   bus.con_out,    32'h0);
    bus.dm_write_1 = 4'hF;
    bus.data_in_1  = 32'hDEADBEEF;
    step();
    check("rst_hold_dout1", bus.data_out_1, 32'h0);
    check("rst_hold_con",   bus.con_out,    32'h0);
    bus.dm_write_1 = 4'h0;
    nrst = 1'b1;
    step();
    check("post_rst_con",   bus.con_out,    32'h22222222);
    check("post_rst_dout1", bus.data_out_1, 32'h22222222);
    check("post_rst_dout0", bus.data_out_0, 32'h11111111);

    // Randomized traffic over a small row window so port reads, writes and console collide
    for (int c = 0; c < 400; c++) begin
      logic [3:0][3:0]    we;
      logic [3:0][AB-1:0] a;
      logic [3:0][DW-1:0] d;
      logic [AB-1:0]      ca;
      logic [DW-1:0]      exp_d [4];
      bit                 ok_d  [4];
      logic [DW-1:0]      exp_c;
      bit                 ok_c;
      for (int p = 0; p < 4; p++) begin
        a[p]  = AB'(($urandom_range(0, 15) * 4) + p);
        we[p] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        d[p]  = $urandom;
        exp_d[p] = model_mem[int'(a[p])];
        ok_d[p]  = (model_vld[int'(a[p])] == 4'hF);
      end
      ca    = AB'($urandom_range(0, 63));
      exp_c = model_mem[int'(ca)];
      ok_c  = (model_vld[int'(ca)] == 4'hF);
      set_bus(we, a, d, ca);
      step();
      for (int p = 0; p < 4; p++) begin
        if (ok_d[p]) check($sformatf("rand%0d_dout%0d", c, p), dout(p), exp_d[p]);
      end
      if (ok_c) check($sformatf("rand%0d_con", c), bus.con_out, exp_c);
      model_ports(we, a, d);
    end

    set_bus('0, '0, '0, '0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
